// File: rtl/dsp_pkg.sv
// Shared constants and sizing helpers for the DSP chain.
// The decimator uses them to derive its internal accumulator width.
package dsp_pkg;

    // Largest decimation exponent accepted by default; larger requests clamp here.
    localparam int CIC_DEFAULT_MAX_RATE_LOG2 = 6;

    // Bit growth of an N-stage CIC is N*log2(R), so this width never loses MSBs.
    function automatic int cic_acc_width(input int data_w, input int order, input int max_rate_log2);
        return data_w + order * max_rate_log2;
    endfunction

endpackage

// File: rtl/cic_comb.sv
// One registered comb stage (differential delay 1) for N parallel channels.
// A sideband word travels with each valid sample.
module cic_comb #(
    parameter int N  = 2,
    parameter int W  = 34,
    parameter int SW = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                valid_i,
    input  logic [N-1:0][W-1:0] data_i,
    input  logic [SW-1:0]       side_i,
    output logic                valid_o,
    output logic [N-1:0][W-1:0] data_o,
    output logic [SW-1:0]       side_o
);

    logic                valid_q, valid_d;
    logic [N-1:0][W-1:0] dly_q, dly_d;
    logic [N-1:0][W-1:0] out_q, out_d;
    logic [SW-1:0]       side_q, side_d;

    always_comb begin
        valid_d = valid_q;
        dly_d   = dly_q;
        out_d   = out_q;
        side_d  = side_q;
        if (en_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                for (int ch = 0; ch < N; ch++) begin
                    out_d[ch] = data_i[ch] - dly_q[ch];
                    dly_d[ch] = data_i[ch];
                end
                side_d = side_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            dly_q   <= '0;
            out_q   <= '0;
            side_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dly_q   <= dly_d;
            out_q   <= out_d;
            side_q  <= side_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = out_q;
    assign side_o  = side_q;

endmodule

// File: rtl/cic_decimator.sv
// Multichannel CIC decimator: ORDER integrators, 2^rate decimation, ORDER combs,
// then a gain-normalising arithmetic right shift by ORDER*rate.
module cic_decimator
    import dsp_pkg::*;
#(
    parameter int IQ_NUM        = 2,
    parameter int DATA_WIDTH    = 16,
    parameter int ORDER         = 3,
    parameter int MAX_RATE_LOG2 = CIC_DEFAULT_MAX_RATE_LOG2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 en_i,
    input  logic [$clog2(MAX_RATE_LOG2+1)-1:0]   rate_log2_i,
    input  logic                                 tvalid_i,
    input  logic [IQ_NUM-1:0][DATA_WIDTH-1:0]    tdata_i,
    output logic                                 tvalid_o,
    output logic [IQ_NUM-1:0][DATA_WIDTH-1:0]    tdata_o
);

    localparam int ACC_WIDTH = cic_acc_width(DATA_WIDTH, ORDER, MAX_RATE_LOG2);
    localparam int RW        = $clog2(MAX_RATE_LOG2 + 1);
    localparam int CW        = (MAX_RATE_LOG2 > 0) ? MAX_RATE_LOG2 : 1;

    // Handshake: a sample is taken whenever en_i & tvalid_i; there is no ready, the
    // upstream is never stalled, and tvalid_o is a one-cycle strobe while en_i is high.
    logic accept;
    logic group_end;
    logic [RW-1:0] rate_in, cur_rate;
    logic [CW:0]   one_hot;
    logic [CW-1:0] last_cnt;

    logic [IQ_NUM-1:0][ORDER-1:0][ACC_WIDTH-1:0] integ_q, integ_d;
    logic [ACC_WIDTH-1:0]                        integ_carry;
    logic [CW-1:0]                               cnt_q, cnt_d;
    logic [RW-1:0]                               rate_q, rate_d;
    logic                                        dec_valid_q, dec_valid_d;
    logic [IQ_NUM-1:0][ACC_WIDTH-1:0]            dec_data_q, dec_data_d;
    logic [RW-1:0]                               dec_rate_q, dec_rate_d;
    logic                                        out_valid_q, out_valid_d;
    logic [IQ_NUM-1:0][DATA_WIDTH-1:0]           out_data_q, out_data_d;

    logic [ORDER:0]                   comb_valid;
    logic [IQ_NUM-1:0][ACC_WIDTH-1:0] comb_data [0:ORDER];
    logic [RW-1:0]                    comb_rate [0:ORDER];
    logic signed [ACC_WIDTH-1:0]      shifted;
    int                               shift_amt;

    // A group's first sample compares against the live rate; later samples use the latched one.
    always_comb begin
        accept    = en_i & tvalid_i;
        rate_in   = (rate_log2_i > RW'(MAX_RATE_LOG2)) ? RW'(MAX_RATE_LOG2) : rate_log2_i;
        cur_rate  = (cnt_q == '0) ? rate_in : rate_q;
        one_hot   = (CW+1)'(1) << cur_rate;
        last_cnt  = one_hot[CW-1:0] - CW'(1);
        group_end = (cnt_q == last_cnt);
        cnt_d     = cnt_q;
        rate_d    = rate_q;
        if (accept) begin
            if (cnt_q == '0) begin
                rate_d = rate_in;
            end
            cnt_d = group_end ? '0 : cnt_q + CW'(1);
        end
    end

    // Integrators wrap modulo 2^ACC_WIDTH; the combs undo the wrap exactly.
    always_comb begin
        integ_d     = integ_q;
        integ_carry = '0;
        for (int ch = 0; ch < IQ_NUM; ch++) begin
            integ_carry = ACC_WIDTH'($signed(tdata_i[ch]));
            for (int k = 0; k < ORDER; k++) begin
                integ_carry = integ_q[ch][k] + integ_carry;
                if (accept) begin
                    integ_d[ch][k] = integ_carry;
                end
            end
        end
    end

    always_comb begin
        dec_valid_d = dec_valid_q;
        dec_data_d  = dec_data_q;
        dec_rate_d  = dec_rate_q;
        if (en_i) begin
            dec_valid_d = accept & group_end;
            if (accept & group_end) begin
                for (int ch = 0; ch < IQ_NUM; ch++) begin
                    dec_data_d[ch] = integ_d[ch][ORDER-1];
                end
                dec_rate_d = cur_rate;
            end
        end
    end

    assign comb_valid[0] = dec_valid_q;
    assign comb_data[0]  = dec_data_q;
    assign comb_rate[0]  = dec_rate_q;

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        cic_comb #(
            .N  (IQ_NUM),
            .W  (ACC_WIDTH),
            .SW (RW)
        ) u_comb (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (en_i),
            .valid_i (comb_valid[k]),
            .data_i  (comb_data[k]),
            .side_i  (comb_rate[k]),
            .valid_o (comb_valid[k+1]),
            .data_o  (comb_data[k+1]),
            .side_o  (comb_rate[k+1])
        );
    end

    // Gain is R^ORDER = 2^(ORDER*rate), so a floor shift normalises exactly.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        shift_amt   = ORDER * int'(comb_rate[ORDER]);
        shifted     = '0;
        if (en_i) begin
            out_valid_d = comb_valid[ORDER];
            if (comb_valid[ORDER]) begin
                for (int ch = 0; ch < IQ_NUM; ch++) begin
                    shifted        = $signed(comb_data[ORDER][ch]) >>> shift_amt;
                    out_data_d[ch] = shifted[DATA_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            integ_q     <= '0;
            cnt_q       <= '0;
            rate_q      <= '0;
            dec_valid_q <= 1'b0;
            dec_data_q  <= '0;
            dec_rate_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            integ_q     <= integ_d;
            cnt_q       <= cnt_d;
            rate_q      <= rate_d;
            dec_valid_q <= dec_valid_d;
            dec_data_q  <= dec_data_d;
            dec_rate_q  <= dec_rate_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign tvalid_o = out_valid_q;
    assign tdata_o  = out_data_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: ORDER=3 and ORDER=2 instances share one stimulus stream and
// are compared against a binomial-sum CIC reference model with latency tracking.
module tb_cic_decimator;

    typedef struct packed {
        logic [31:0] data;
        int          t_end;
        int          stall_at;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              tvalid = 1'b0;
    logic [2:0]        rate = 3'd0;
    logic [1:0][15:0]  tdata = '0;
    logic              tvalid3, tvalid2;
    logic [1:0][15:0]  tdata3, tdata2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall = 0;
    logic last_en = 1'b0;

    int          cnt_m, grate_m;
    longint      xi_q[$];
    longint      xq_q[$];
    longint      hist [2][2][1024];
    int          hist_n [2];
    exp_t        exp3_q[$];
    exp_t        exp2_q[$];
    logic [31:0] got3_q[$];
    logic [31:0] got2_q[$];
    logic [31:0] ref_q[$];

    always #5 clk = ~clk;

    cic_decimator #(.IQ_NUM(2), .DATA_WIDTH(16), .ORDER(3), .MAX_RATE_LOG2(6)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .rate_log2_i(rate), .tvalid_i(tvalid),
        .tdata_i(tdata), .tvalid_o(tvalid3), .tdata_o(tdata3)
    );

    cic_decimator #(.IQ_NUM(2), .DATA_WIDTH(16), .ORDER(2), .MAX_RATE_LOG2(6)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .rate_log2_i(rate), .tvalid_i(tvalid),
        .tdata_i(tdata), .tvalid_o(tvalid2), .tdata_o(tdata2)
    );

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * longint'(n - i) / longint'(i + 1);
        return r;
    endfunction

    // Output of an o-fold running sum at the newest sample, as a binomial-weighted sum.
    function automatic longint integ_at(input int o, input int ch);
        longint s = 0;
        int n = xi_q.size();
        for (int j = 0; j < n; j++) begin
            s += binom(j + o - 1, o - 1) * ((ch == 0) ? xi_q[n-1-j] : xq_q[n-1-j]);
        end
        return s;
    endfunction

    // o-th backward difference across group ends, wrapped to the accumulator width, then shifted.
    function automatic logic [15:0] comb_out(input int oi, input int ch, input int gr);
        int o = (oi == 0) ? 3 : 2;
        int m = hist_n[oi] - 1;
        int acc = 16 + o * 6;
        longint d = 0;
        longint v;
        for (int k = 0; k <= o; k++) begin
            v = (m - k >= 0) ? hist[oi][ch][m-k] : 64'sd0;
            if (k % 2 == 1) d -= binom(o, k) * v;
            else d += binom(o, k) * v;
        end
        d = (d <<< (64 - acc)) >>> (64 - acc);
        d = d >>> (o * gr);
        return d[15:0];
    endfunction

    task automatic model_reset();
        cnt_m = 0;
        grate_m = 0;
        xi_q.delete();
        xq_q.delete();
        hist_n[0] = 0;
        hist_n[1] = 0;
        exp3_q.delete();
        exp2_q.delete();
        got3_q.delete();
        got2_q.delete();
    endtask

    task automatic model_accept(input logic [15:0] di, input logic [15:0] dq, input logic [2:0] r);
        exp_t e;
        if (cnt_m == 0) grate_m = (r > 3'd6) ? 6 : int'(r);
        xi_q.push_back(longint'($signed(di)));
        xq_q.push_back(longint'($signed(dq)));
        cnt_m++;
        if (cnt_m == (1 << grate_m)) begin
            cnt_m = 0;
            for (int oi = 0; oi < 2; oi++) begin
                if (hist_n[oi] < 1024) begin
                    hist[oi][0][hist_n[oi]] = integ_at((oi == 0) ? 3 : 2, 0);
                    hist[oi][1][hist_n[oi]] = integ_at((oi == 0) ? 3 : 2, 1);
                    hist_n[oi]++;
                end
                e.data = {comb_out(oi, 1, grate_m), comb_out(oi, 0, grate_m)};
                e.t_end = cyc;
                e.stall_at = stall;
                if (oi == 0) exp3_q.push_back(e);
                else exp2_q.push_back(e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_out(input int oi, input logic v, input logic [31:0] d);
        exp_t e;
        bit have;
        int lat;
        int o = (oi == 0) ? 3 : 2;
        have = (oi == 0) ? (exp3_q.size() > 0) : (exp2_q.size() > 0);
        e = '0;
        if (have) e = (oi == 0) ? exp3_q[0] : exp2_q[0];
        lat = have ? (cyc - e.t_end + 1 - (stall - e.stall_at)) : 0;
        if (!last_en) return;
        if (v) begin
            if (oi == 0) got3_q.push_back(d);
            else got2_q.push_back(d);
            checks++;
            assert (have) else begin
                errors++;
                $error("FAIL spurious_valid order=%0d got=%h exp=none", o, d);
            end
            if (have) begin
                if (oi == 0) void'(exp3_q.pop_front());
                else void'(exp2_q.pop_front());
                checks++;
                assert (d === e.data) else begin
                    errors++;
                    $error("FAIL data order=%0d got=%h exp=%h", o, d, e.data);
                end
                checks++;
                assert (lat == o + 2) else begin
                    errors++;
                    $error("FAIL latency order=%0d got=%0d exp=%0d", o, lat, o + 2);
                end
            end
        end else if (have && lat >= o + 2) begin
            if (oi == 0) void'(exp3_q.pop_front());
            else void'(exp2_q.pop_front());
            checks++;
            assert (v === 1'b1) else begin
                errors++;
                $error("FAIL missing_valid order=%0d got=%b exp=1 data=%h", o, v, e.data);
            end
        end
    endtask

    // One clock: drive inputs, let the model see the edge, then sample outputs at the falling edge.
    task automatic step(input logic en_v, input logic v_v, input logic [15:0] di, input logic [15:0] dq,
                        input logic [2:0] r, input logic rst_v);
        en = en_v;
        tvalid = v_v;
        tdata[0] = di;
        tdata[1] = dq;
        rate = r;
        rst = rst_v;
        if (rst_v) model_reset();
        @(posedge clk);
        cyc++;
        last_en = en_v;
        if (!en_v) stall++;
        if (!rst_v && en_v && v_v) model_accept(di, dq, r);
        @(negedge clk);
        if (!rst_v) begin
            check_out(0, tvalid3, tdata3);
            check_out(1, tvalid2, tdata2);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 16'd0, 16'd0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        repeat (2) step(1'b0, 1'b0, 16'd0, 16'd0, 3'd0, 1'b1);
    endtask

    initial begin
        logic [31:0] w;
        int sent;
        bit stalled;
        logic v;

        // Reset state
        do_reset();
        chk("rst_tvalid3", 32'(tvalid3), 32'd0);
        chk("rst_tdata3", tdata3, 32'd0);
        chk("rst_tvalid2", 32'(tvalid2), 32'd0);
        chk("rst_tdata2", tdata2, 32'd0);
        step(1'b0, 1'b0, 16'd0, 16'd0, 3'd0, 1'b0);

        // R=1 ramp: identity with 5-cycle latency
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 16'(i), 16'(-i), 3'd0, 1'b0);
        idle(10);
        chk("ramp_count", 32'(got3_q.size()), 32'd40);
        for (int i = 0; i < 40; i += 13) begin
            w = (i < got3_q.size()) ? got3_q[i] : 32'hxxxxxxxx;
            chk("ramp_value", w, {16'(-i), 16'(i)});
        end

        // DC 1000/-1000 at R=8
        do_reset();
        for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 16'd1000, 16'(-1000), 3'd3, 1'b0);
        idle(10);
        chk("dc_count", 32'(got3_q.size()), 32'd10);
        for (int k = 3; k < got3_q.size(); k++) chk("dc_steady3", got3_q[k], {16'(-1000), 16'd1000});

        // Full scale at R=64
        do_reset();
        for (int i = 0; i < 64 * 6; i++) step(1'b1, 1'b1, 16'h7fff, 16'h8000, 3'd6, 1'b0);
        idle(10);
        w = (got3_q.size() > 0) ? got3_q[got3_q.size()-1] : 32'hxxxxxxxx;
        chk("fullscale3", w, {16'h8000, 16'h7fff});
        w = (got2_q.size() > 0) ? got2_q[got2_q.size()-1] : 32'hxxxxxxxx;
        chk("fullscale2", w, {16'h8000, 16'h7fff});

        // Rate request above maximum clamps to 64
        do_reset();
        for (int i = 0; i < 64 * 5; i++) step(1'b1, 1'b1, 16'd1234, 16'(-1234), 3'd7, 1'b0);
        idle(10);
        chk("clamp_count", 32'(got3_q.size()), 32'd5);
        w = (got3_q.size() > 0) ? got3_q[got3_q.size()-1] : 32'hxxxxxxxx;
        chk("clamp_steady", w, {16'(-1234), 16'd1234});

        // Impulse 8192 at R=4 on the ORDER=2 instance
        do_reset();
        step(1'b1, 1'b1, 16'd8192, 16'd0, 3'd2, 1'b0);
        for (int i = 0; i < 19; i++) step(1'b1, 1'b1, 16'd0, 16'd0, 3'd2, 1'b0);
        idle(8);
        for (int k = 0; k < 3; k++) begin
            w = (k < got2_q.size()) ? got2_q[k] : 32'hxxxxxxxx;
            chk("impulse2", w, (k == 0) ? 32'd2048 : 32'd0);
        end

        // Constant 500 at R=4 without gaps, then with random gaps and an enable pause
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 16'd500, 16'(-500), 3'd2, 1'b0);
        idle(10);
        ref_q = got3_q;
        do_reset();
        sent = 0;
        stalled = 0;
        while (sent < 40) begin
            if (sent == 14 && !stalled) begin
                repeat (7) step(1'b0, 1'b1, 16'd500, 16'(-500), 3'd2, 1'b0);
                stalled = 1;
            end
            v = 1'($urandom_range(0, 1));
            step(1'b1, v, 16'd500, 16'(-500), 3'd2, 1'b0);
            if (v) sent++;
        end
        idle(10);
        chk("gap_count", 32'(got3_q.size()), 32'(ref_q.size()));
        for (int k = 0; k < ref_q.size(); k++) begin
            w = (k < got3_q.size()) ? got3_q[k] : 32'hxxxxxxxx;
            chk("gap_seq", w, ref_q[k]);
        end

        // Rate 2 -> 4 mid-group, then reset mid-group
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 3'd2, 1'b0);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 3'd4, 1'b0);
        idle(8);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 3'd4, 1'b0);
        chk("ratechg_count", 32'(got3_q.size()), 32'd2);
        do_reset();
        chk("midrst_tvalid3", 32'(tvalid3), 32'd0);
        chk("midrst_tdata3", tdata3, 32'd0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 16'd0, 16'd0, 3'd2, 1'b0);
        idle(8);
        chk("postrst_count", 32'(got3_q.size()), 32'd3);
        for (int k = 0; k < got3_q.size(); k++) chk("postrst_zero", got3_q[k], 32'd0);

        // Random data, rates, valid and enable against the model
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 15) == 0) rate = 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
                 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), rate, 1'b0);
        end
        idle(20);
        chk("drain3", 32'(exp3_q.size()), 32'd0);
        chk("drain2", 32'(exp2_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
Multichannel CIC decimator that consumes the complex baseband stream produced by the mixer stage. Each channel (I/Q) passes through ORDER integrators at the input rate, then a 2^rate_log2 decimator, then ORDER combs (differential delay 1). The CIC gain is normalised by an exact arithmetic right shift. The output feeds the compensation FIR and the channel filter chain.

Parameters:
IQ_NUM, 2, number of parallel channels; all channels share one valid and one decimation counter
DATA_WIDTH, 16, input and output sample width, signed two's complement
ORDER, 3, number of integrator stages and number of comb stages (legal range 1..6)
MAX_RATE_LOG2, 6, maximum decimation exponent; maximum decimation factor is 2^MAX_RATE_LOG2
ACC_WIDTH, DATA_WIDTH+ORDER*MAX_RATE_LOG2, internal width (derived localparam, not overridable)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
en_i  input  1  global enable; 0 freezes all state, ignores tvalid_i, holds outputs
rate_log2_i  input  $clog2(MAX_RATE_LOG2+1)  decimation exponent R=2^rate_log2_i; values above MAX_RATE_LOG2 clamp to MAX_RATE_LOG2
tvalid_i  input  1  input sample valid
tdata_i  input  [IQ_NUM-1:0][DATA_WIDTH-1:0]  signed input samples, index 0 = I, index 1 = Q
tvalid_o  output  1  one-cycle pulse per decimated output sample
tdata_o  output  [IQ_NUM-1:0][DATA_WIDTH-1:0]  signed decimated samples

Behaviour:
- Reset (async assert, release on clock edge): all integrators, comb delays, pipeline registers, decimation counter and latched rate = 0; tvalid_o=0; tdata_o=0.
- No backpressure. Accept a sample on the cycle where en_i & tvalid_i = 1. Gaps in tvalid_i are allowed and leave integrators unchanged.
- Integrators: on each accepted sample, all ORDER stages update in the same cycle as a combinational adder chain. integ[0]+=x (sign-extended), integ[k]+=integ_next[k-1]. Wrap-around modulo 2^ACC_WIDTH is intentional and required for correctness.
- Decimation counter: counts accepted samples 0..R-1.
  - When counter==0 on an accepted sample, latch rate_log2_i (clamped) as the group rate. The comparison on that same sample uses the incoming value directly.
  - A rate change mid-group takes effect only at the next group start.
  - The accepted sample with counter==R-1 ends the group: the counter returns to 0 and the strobe asserts next cycle with integ[ORDER-1] captured.
  - For R=1, every accepted sample ends a group.
- Combs: ORDER registered stages, one cycle each, advancing only on their input valid. c[k]=in-dly[k]; dly[k]<=in.
- Output stage: one register. tdata_o = (comb_out >>> (ORDER*group_rate)) truncated to DATA_WIDTH LSBs (floor, no rounding). The group rate travels with the strobe through the pipeline.
- Latency: the group-ending input at cycle t produces tvalid_o at cycle t+ORDER+2 (en_i held high).
- en_i=0 mid-pipeline stalls every stage, including valid bits. Resuming continues without loss.
- Reset asserted mid-group: the partial group is discarded and in-flight outputs are lost. The first post-reset accepted sample starts a new group.
- Transient: the first ORDER outputs after reset contain start-up transient, which is correct CIC behaviour. Steady-state output equals the input DC value exactly for any R.

Decomposition:
- Package dsp_pkg: function cic_acc_width(data_w, order, max_rate_log2); clamp constant for rate.
- Sub-module cic_comb: one registered comb stage with valid in/out and en_i. Instantiate ORDER times in a generate loop.
- Integrators and decimation counter stay inline.

Test Plan:
- R=1 (rate_log2_i=0), ORDER=3, ramp 0,1,2,… continuous valid -> tdata_o equals input delayed exactly 5 cycles, tvalid_o every cycle.
- Constant I=1000, Q=-1000, rate_log2_i=3, ORDER=3 -> after 3 transient outputs, every output is I=1000, Q=-1000; tvalid_o period 8 cycles.
- Full-scale: I=32767, Q=-32768, rate_log2_i=6 -> steady-state 32767 / -32768, no wrap error.
- Impulse I=8192 then zeros, ORDER=2, rate_log2_i=2 -> outputs 2048, 0, 0 … (h at group end = 4, shift 4).
- Random tvalid_i gaps (~50% duty) plus en_i low for 7 cycles mid-group, constant 500 at R=4 -> same output sequence as the gap-free run, only time-stretched.
- rate_log2_i changed 2->4 mid-group, then rst_i pulsed mid-group -> the current group completes at R=4; after reset all outputs are 0 and the new group starts counting from 0.
